io_trace_buffer: RTL and testbench

- Sits beside the cpu instance and records every output event (out_signal/out_data) into a timestamped circular buffer.
- Tracks run state: RUN until halt, or TIMEOUT if halt never arrives within MAX_CYCLES.
- Exposes a valid/ready drain port so a bench or debug host reads the trace after, or during, execution.
- Generalises the one-channel, print-as-you-go output monitor into a parametrised, buffered, watchdog-protected block.

---
 rtl/io_trace_buffer.sv | 102 ++++++++++
 tb/tb_io_trace_buffer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_trace_buffer.sv
// Timestamped circular trace of cpu output events with a run/halt/timeout watchdog.
// Entries drain through a show-ahead valid/ready port, during or after execution.
module io_trace_buffer #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned CYC_W      = 32,
  parameter int unsigned MAX_CYCLES = 100000,
  parameter int unsigned OVERWRITE  = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       halt,
  input  logic                       out_signal,
  input  logic [DATA_W-1:0]          out_data,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  output logic [CYC_W-1:0]           rd_cycle,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       done,
  output logic                       timeout,
  output logic [CYC_W-1:0]           run_cycles
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam bit          OVW   = (OVERWRITE != 0);
  localparam logic [CYC_W-1:0] LIMIT = CYC_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {StRun, StHalted, StTimeout} state_e;

  state_e             state;
  logic [PTR_W-1:0]   head, tail;
  logic [DATA_W-1:0]  mem_data  [DEPTH];
  logic [CYC_W-1:0]   mem_cycle [DEPTH];

  logic push_req, full, pop, wr_en, drop_evt, ovr_adv, cnt_inc;

  always_comb begin
    rd_valid = (count != '0);
    full     = (count == CNT_W'(DEPTH));
    push_req = (state == StRun) & out_signal;
    pop      = rd_valid & rd_ready;
    // A full buffer with no simultaneous pop either drops or overwrites the event.
    drop_evt = push_req & full & ~pop;
    ovr_adv  = drop_evt & OVW;
    wr_en    = push_req & (~drop_evt | OVW);
    cnt_inc  = wr_en & ~ovr_adv;
    rd_data  = rd_valid ? mem_data[head]  : '0;
    rd_cycle = rd_valid ? mem_cycle[head] : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StRun;
      run_cycles <= '0;
      done       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      case (state)
        StRun: begin
          if (halt) begin
            state      <= StHalted;
            done       <= 1'b1;
            run_cycles <= run_cycles + CYC_W'(1);
          end else if (run_cycles == LIMIT) begin
            // Counter freezes at the limit so it can never wrap.
            state   <= StTimeout;
            timeout <= 1'b1;
          end else begin
            run_cycles <= run_cycles + CYC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) tail <= tail + PTR_W'(1);
      if (pop | ovr_adv) head <= head + PTR_W'(1);
      count <= count + CNT_W'(cnt_inc) - CNT_W'(pop);
      if (drop_evt) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: reads are masked to zero while empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[tail]  <= out_data;
      mem_cycle[tail] <= run_cycles;
    end
  end

endmodule

// File: tb/tb_io_trace_buffer.sv
// Randomised and directed bench for io_trace_buffer: two instances (drop / overwrite policy)
// checked every cycle against a queue-based trace model.
module tb_io_trace_buffer;

  localparam int unsigned DW   = 16;
  localparam int unsigned CW   = 16;
  localparam int unsigned DEP  = 4;
  localparam int unsigned MAXC = 20;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } entry_t;

  logic          clk = 1'b0;
  logic          reset, halt, out_signal, rd_ready;
  logic [DW-1:0] out_data;

  logic          rd_valid   [2];
  logic [DW-1:0] rd_data    [2];
  logic [CW-1:0] rd_cycle   [2];
  logic [2:0]    count      [2];
  logic          overflow   [2];
  logic          done       [2];
  logic          timeout    [2];
  logic [CW-1:0] run_cycles [2];

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    io_trace_buffer #(
      .DATA_W    (DW),
      .DEPTH     (DEP),
      .CYC_W     (CW),
      .MAX_CYCLES(MAXC),
      .OVERWRITE (g)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .halt      (halt),
      .out_signal(out_signal),
      .out_data  (out_data),
      .rd_ready  (rd_ready),
      .rd_valid  (rd_valid[g]),
      .rd_data   (rd_data[g]),
      .rd_cycle  (rd_cycle[g]),
      .count     (count[g]),
      .overflow  (overflow[g]),
      .done      (done[g]),
      .timeout   (timeout[g]),
      .run_cycles(run_cycles[g])
    );

    // Model: q holds the expected trace (front = next read); mstate 0 run, 1 halted, 2 timeout.
    entry_t      q[$];
    int          mstate = 0;
    int unsigned mcyc   = 0;
    bit          movf   = 0;

    always @(negedge clk) begin
      if (reset) begin
        q.delete();
        mstate = 0;
        mcyc   = 0;
        movf   = 0;
      end
      check($sformatf("u%0d.rd_valid", g), 64'(rd_valid[g]), 64'(q.size() != 0));
      check($sformatf("u%0d.count", g), 64'(count[g]), 64'(q.size()));
      check($sformatf("u%0d.overflow", g), 64'(overflow[g]), 64'(movf));
      check($sformatf("u%0d.done", g), 64'(done[g]), 64'(mstate == 1));
      check($sformatf("u%0d.timeout", g), 64'(timeout[g]), 64'(mstate == 2));
      check($sformatf("u%0d.run_cycles", g), 64'(run_cycles[g]), 64'(mcyc));
      if (q.size() != 0) begin
        check($sformatf("u%0d.rd_data", g), 64'(rd_data[g]), 64'(q[0].d));
        check($sformatf("u%0d.rd_cycle", g), 64'(rd_cycle[g]), 64'(q[0].c));
      end else begin
        check($sformatf("u%0d.rd_data_empty", g), 64'(rd_data[g]), 64'd0);
        check($sformatf("u%0d.rd_cycle_empty", g), 64'(rd_cycle[g]), 64'd0);
      end
      if (!reset) begin
        if (rd_ready && q.size() != 0) void'(q.pop_front());
        if (mstate == 0 && out_signal) begin
          if (q.size() < DEP) begin
            q.push_back('{d: out_data, c: CW'(mcyc)});
          end else begin
            movf = 1;
            if (g == 1) begin
              void'(q.pop_front());
              q.push_back('{d: out_data, c: CW'(mcyc)});
            end
          end
        end
        if (mstate == 0) begin
          if (halt) begin
            mstate = 1;
            mcyc++;
          end else if (mcyc == MAXC - 1) begin
            mstate = 2;
          end else begin
            mcyc++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at the start of cycle 0 (run_cycles == 0) with idle inputs.
  task automatic start();
    reset      = 1'b1;
    halt       = 1'b0;
    out_signal = 1'b0;
    rd_ready   = 1'b0;
    out_data   = DW'($urandom);
    tick();
    reset = 1'b0;
  endtask

  task automatic drain(input int n);
    out_signal = 1'b0;
    halt       = 1'b1;
    rd_ready   = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    reset      = 1'b1;
    halt       = 1'b0;
    out_signal = 1'b0;
    rd_ready   = 1'b0;
    out_data   = '0;
    tick();

    // Two events then halt, drained afterwards.
    start();
    for (int k = 0; k < 16; k++) begin
      out_signal = (k == 3) || (k == 7);
      out_data   = (k == 3) ? DW'(16'h00A5) : (k == 7) ? DW'(16'h1234) : DW'($urandom);
      halt       = (k >= 10);
      rd_ready   = (k >= 11);
      tick();
    end

    // Six back-to-back events into a four-deep buffer, no reads.
    start();
    for (int k = 0; k < 6; k++) begin
      out_signal = 1'b1;
      out_data   = DW'(k + 1);
      tick();
    end
    out_signal = 1'b0;
    tick();
    drain(6);

    // Full buffer with push and pop in the same cycle.
    start();
    for (int k = 0; k < 4; k++) begin
      out_signal = 1'b1;
      out_data   = DW'(k + 1);
      tick();
    end
    out_data = DW'(5);
    rd_ready = 1'b1;
    tick();
    out_signal = 1'b0;
    rd_ready   = 1'b0;
    tick();
    drain(6);

    // Watchdog expiry with random traffic continuing afterwards.
    start();
    for (int k = 0; k < 30; k++) begin
      out_signal = 1'($urandom_range(0, 1));
      out_data   = DW'($urandom);
      rd_ready   = ($urandom_range(0, 3) == 0);
      tick();
    end

    // Halt arriving in the same cycle as the watchdog limit.
    start();
    for (int k = 0; k < 23; k++) begin
      halt       = (k >= 19);
      out_signal = (k == 19);
      out_data   = DW'($urandom);
      tick();
    end

    // Asynchronous reset mid-cycle with three entries buffered and overflow clear.
    start();
    for (int k = 0; k < 3; k++) begin
      out_signal = 1'b1;
      out_data   = DW'(16'h0100 + k);
      tick();
    end
    out_signal = 1'b0;
    #2 reset = 1'b1;
    tick();
    reset = 1'b0;
    out_signal = 1'b1;
    out_data   = DW'(16'hBEEF);
    tick();
    out_signal = 1'b0;
    tick();
    drain(3);

    // Random runs.
    repeat (40) begin
      start();
      for (int k = 0; k < int'($urandom_range(8, 30)); k++) begin
        out_signal = ($urandom_range(0, 3) != 0);
        out_data   = DW'($urandom);
        rd_ready   = ($urandom_range(0, 2) == 0);
        halt       = halt | ($urandom_range(0, 24) == 0);
        tick();
      end
      drain(5);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
